demux1_8_16b_wq: RTL
====================

DEMUX1_8_16B_WQ -- requirements
Module: demux1_8_16b_wq

Interface
REQ-001 Parameter DATA_W, default 16: width of each destination register and of wr_data.
REQ-002 Parameter DEPTH, default 2: number of write-queue entries; fixed at 2 for this release.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 wr_valid  input  1  write request present this cycle.
REQ-006 wr_sel  input  3  destination index: 3'b000 selects Out1 through 3'b111 selects Out8.
REQ-007 wr_data  input  DATA_W  value to write.
REQ-008 hold  input  1  while high, the queue does not drain.
REQ-009 wr_ready  output  1  queue can accept a write this cycle.
REQ-010 busy  output  1  queue holds at least one pending write.
REQ-011 Out1..Out8  output  DATA_W each  destination register contents.
REQ-012 err  output  1  sticky overflow flag.

Function
REQ-013 The block SHALL be the write-side counterpart of the 8:1 16-bit read mux: it routes one (wr_sel, wr_data) pair into one of eight registers.
REQ-014 A write SHALL be accepted on a rising edge where wr_valid=1 and wr_ready=1; sel and data are pushed to the queue tail.
REQ-015 wr_ready SHALL equal (count < DEPTH) and be combinational from registered count only, with no path from wr_valid.
REQ-016 busy SHALL equal (count != 0).
REQ-017 On each rising edge where count>0 and hold=0, the head entry SHALL pop and write Out[head_sel] <= head_data; the other seven registers hold.
REQ-018 Latency: with an empty queue and hold=0, a write accepted at edge N SHALL appear on Out at edge N+1, giving 2 edges from request to visible value; there is no bypass.
REQ-019 Simultaneous push and pop SHALL leave count unchanged; a push into a full queue in the same cycle as a pop is not permitted, because wr_ready is 0 when count=DEPTH.
REQ-020 Writes SHALL retire in acceptance order; consecutive writes to the same index leave the later value.
REQ-021 The queue SHALL use wrap-around read and write pointers of width clog2(DEPTH), modulo DEPTH.
REQ-022 On any edge with wr_valid=1 and wr_ready=0, err SHALL set to 1 and stay at 1 until reset; the request is dropped and queue state is unchanged.
REQ-023 hold=1 SHALL still allow pushes while count<DEPTH.
REQ-024 wr_sel and wr_data SHALL be ignored when wr_valid=0.

Reset
REQ-025 While rst=1, and asynchronously on assertion: Out1..Out8=16'h0000, count=0, both pointers=0, err=0.
REQ-026 wr_ready SHALL be 0 while rst=1 and 1 on the first cycle after release.
REQ-027 Reset during pending writes SHALL discard them; no partial register update.

Structure
REQ-028 DATA_W, SEL_W=3, DEPTH=2 and the index-to-output mapping SHALL live in the shared processor constants include.
REQ-029 The queue SHALL be one sub-module, wq_fifo, with push, pop, count and head outputs; the 1:8 decode and the eight registers live in the top.

Verification
REQ-030 Single write: sel=3'b101, data=16'hABCD, hold=0 -> Out6=16'hABCD two edges later; all other outputs 16'h0000; busy high exactly one cycle.
REQ-031 Back-to-back: writes to sel 0,1,2 on consecutive cycles with data 1,2,3 -> Out1..Out3=1,2,3 on successive edges; wr_ready stays 1; err=0.
REQ-032 Fill and overflow: hold=1, three consecutive writes -> wr_ready drops after the second; the third sets err=1; after hold=0, only the first two values land.
REQ-033 Same-index ordering: hold=1, write sel=7 with 16'h1111 then 16'h2222, release hold -> Out8 shows 16'h1111 then 16'h2222 on consecutive edges.
REQ-034 Mid-operation reset: two entries queued, then rst pulsed asynchronously between edges -> all outputs 0, busy=0, err=0 immediately; no queued value appears afterwards.
REQ-035 Push+pop at count=1: queue one entry with hold=0, then push another the next cycle -> count stays 1 and both writes land in order.

Source files
------------

// File: rtl/demux1_8_16b_wq_pkg.sv
// Shared constants for the 1:8 write-queue demux: widths, queue depth,
// and the destination-index to output-register mapping.
package demux1_8_16b_wq_pkg;

  localparam int WQ_DATA_W   = 16;
  localparam int WQ_SEL_W    = 3;
  localparam int WQ_DEPTH    = 2;
  localparam int WQ_NUM_DEST = 8;

  // Destination index N selects output register Out(N+1)
  typedef enum logic [WQ_SEL_W-1:0] {
    SEL_OUT1 = 3'd0,
    SEL_OUT2 = 3'd1,
    SEL_OUT3 = 3'd2,
    SEL_OUT4 = 3'd3,
    SEL_OUT5 = 3'd4,
    SEL_OUT6 = 3'd5,
    SEL_OUT7 = 3'd6,
    SEL_OUT8 = 3'd7
  } dest_sel_e;

  // One-hot decode of a destination index into per-register write strobes
  function automatic logic [WQ_NUM_DEST-1:0] sel_onehot(input logic [WQ_SEL_W-1:0] sel);
    sel_onehot      = '0;
    sel_onehot[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/demux1_8_16b_wq_if.sv
// Bus bundle for the write-queue demux: write request side plus the
// eight destination registers and status flags.
interface demux1_8_16b_wq_if
  import demux1_8_16b_wq_pkg::*;
#(
  parameter int DATA_W = WQ_DATA_W
);

  logic                wr_valid;
  logic [WQ_SEL_W-1:0] wr_sel;
  logic [DATA_W-1:0]   wr_data;
  logic                hold;
  logic                wr_ready;
  logic                busy;
  logic                err;
  logic [DATA_W-1:0]   Out1;
  logic [DATA_W-1:0]   Out2;
  logic [DATA_W-1:0]   Out3;
  logic [DATA_W-1:0]   Out4;
  logic [DATA_W-1:0]   Out5;
  logic [DATA_W-1:0]   Out6;
  logic [DATA_W-1:0]   Out7;
  logic [DATA_W-1:0]   Out8;

  modport master (
    output wr_valid, wr_sel, wr_data, hold,
    input  wr_ready, busy, err,
    input  Out1, Out2, Out3, Out4, Out5, Out6, Out7, Out8
  );

  modport slave (
    input  wr_valid, wr_sel, wr_data, hold,
    output wr_ready, busy, err,
    output Out1, Out2, Out3, Out4, Out5, Out6, Out7, Out8
  );

endinterface

// File: rtl/demux1_8_16b_wq_wq_fifo.sv
// Small circular write queue holding (sel, data) pairs with wrap-around
// read/write pointers and an occupancy count.
module wq_fifo #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 3,
  parameter int DEPTH  = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [SEL_W-1:0]  sel_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [CNT_W-1:0]  count_o,
  output logic [SEL_W-1:0]  head_sel_o,
  output logic [DATA_W-1:0] head_data_o
);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [SEL_W-1:0]  sel_mem_q  [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Next-state pointers and count; a simultaneous push and pop leaves count as is
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = ptr_next(wr_ptr_q);
    if (pop_i)  rd_ptr_d = ptr_next(rd_ptr_q);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count state; reset empties the queue so stale entries are never read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset because occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (push_i) begin
      sel_mem_q[wr_ptr_q]  <= sel_i;
      data_mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign count_o     = count_q;
  assign head_sel_o  = sel_mem_q[rd_ptr_q];
  assign head_data_o = data_mem_q[rd_ptr_q];

endmodule

// File: rtl/demux1_8_16b_wq.sv
// 1:8 write demux behind a two-entry write queue: accepted writes are
// queued and retired in order into one of eight destination registers.
module demux1_8_16b_wq
  import demux1_8_16b_wq_pkg::*;
#(
  parameter int DATA_W = WQ_DATA_W,
  parameter int DEPTH  = WQ_DEPTH
) (
  input logic              clk,
  input logic              rst,
  demux1_8_16b_wq_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0]       count;
  logic [WQ_SEL_W-1:0]    head_sel;
  logic [DATA_W-1:0]      head_data;
  logic                   ready;
  logic                   push;
  logic                   pop;
  logic [WQ_NUM_DEST-1:0] dest_hit;
  logic [DATA_W-1:0]      out_q [WQ_NUM_DEST];
  logic                   err_q;

  assign ready    = !rst && (count < CNT_W'(DEPTH));
  assign push     = bus.wr_valid && ready;
  assign pop      = (count != '0) && !bus.hold;
  assign dest_hit = sel_onehot(head_sel);

  wq_fifo #(
    .DATA_W (DATA_W),
    .SEL_W  (WQ_SEL_W),
    .DEPTH  (DEPTH)
  ) u_wq_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .pop_i       (pop),
    .sel_i       (bus.wr_sel),
    .data_i      (bus.wr_data),
    .count_o     (count),
    .head_sel_o  (head_sel),
    .head_data_o (head_data)
  );

  // Sticky overflow flag: any request refused for lack of space sets it until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (bus.wr_valid && !ready) begin
      err_q <= 1'b1;
    end
  end

  // Destination registers: only the register addressed by the retiring head entry loads
  for (genvar i = 0; i < WQ_NUM_DEST; i++) begin : g_dest
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_q[i] <= '0;
      end else if (pop && dest_hit[i]) begin
        out_q[i] <= head_data;
      end
    end
  end

  assign bus.wr_ready = ready;
  assign bus.busy     = (count != '0);
  assign bus.err      = err_q;
  assign bus.Out1     = out_q[SEL_OUT1];
  assign bus.Out2     = out_q[SEL_OUT2];
  assign bus.Out3     = out_q[SEL_OUT3];
  assign bus.Out4     = out_q[SEL_OUT4];
  assign bus.Out5     = out_q[SEL_OUT5];
  assign bus.Out6     = out_q[SEL_OUT6];
  assign bus.Out7     = out_q[SEL_OUT7];
  assign bus.Out8     = out_q[SEL_OUT8];

endmodule
